dram_bank_ctrl: RTL and testbench
=================================

DRAM_BANK_CTRL -- requirements
Module: dram_bank_ctrl

Interface
REQ-001 Parameter NUM_BANKS, default 4: number of independent banks, each with its own open-row register.
REQ-002 Parameter ROW_BITS, default 4: row address width.
REQ-003 Parameter COL_BITS, default 2: column address width.
REQ-004 Parameter DATA_WIDTH, default 32: word width.
REQ-005 Parameter T_RP, default 1: precharge cycles, minimum 1.
REQ-006 Parameter T_RCD, default 1: activate cycles, minimum 1.
REQ-007 Parameter REFRESH_PERIOD, default 64, and T_RFC, default 4: refresh interval and refresh duration in cycles, used only with DRAM_REFRESH_EN.
REQ-008 clk  input  1  single clock; all state updates on rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 req_valid  input  1  request present.
REQ-011 req_ready  output  1  controller can accept a request this cycle.
REQ-012 req_write  input  1  1 = write, 0 = read.
REQ-013 req_bank  input  clog2(NUM_BANKS)  target bank.
REQ-014 req_row  input  ROW_BITS  target row.
REQ-015 req_col  input  COL_BITS  target column.
REQ-016 req_wdata  input  DATA_WIDTH  write data.
REQ-017 rsp_valid  output  1  one-cycle completion pulse.
REQ-018 rsp_rdata  output  DATA_WIDTH  read data; for writes, the written word.
REQ-019 rsp_hit  output  1  qualified by rsp_valid; 1 = request hit the open row.

Function
REQ-020 Storage SHALL be NUM_BANKS x 2^ROW_BITS x 2^COL_BITS words of DATA_WIDTH bits; array contents SHALL not be reset.
REQ-021 FSM states SHALL be IDLE, PRECHARGE, ACTIVATE, ACCESS and REFRESH; req_ready SHALL be 1 only in IDLE when no refresh is pending.
REQ-022 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; all request fields SHALL be captured at that edge.
REQ-023 Hit (bank open, same row): IDLE->ACCESS; rsp_valid SHALL rise 1 edge after acceptance, with rsp_hit=1.
REQ-024 Closed bank: IDLE->ACTIVATE(T_RCD)->ACCESS; latency SHALL be 1+T_RCD edges, with rsp_hit=0.
REQ-025 Conflict (bank open, different row): IDLE->PRECHARGE(T_RP)->ACTIVATE(T_RCD)->ACCESS; latency SHALL be 1+T_RP+T_RCD edges, with rsp_hit=0.
REQ-026 The target bank's open row SHALL equal the requested row after ACTIVATE; other banks' open rows SHALL be unchanged.
REQ-027 ACCESS SHALL perform the read or write and return to IDLE on the next edge; rsp_valid SHALL be high in that IDLE cycle, so req_ready and rsp_valid may be high together.
REQ-028 A read following a write to the same address SHALL return the new data.
REQ-029 rsp_valid SHALL be exactly one cycle wide, with no backpressure; rsp_rdata SHALL hold its value until the next response.
REQ-030 Requests with req_valid=1 while req_ready=0 SHALL be ignored; the requester SHALL hold the request.

Reset
REQ-031 When rst_n=0, the controller SHALL immediately force state=IDLE, clear all banks to closed, and set req_ready=0, rsp_valid=0, rsp_hit=0 and rsp_rdata=0.
REQ-032 req_ready SHALL rise on the first rising edge after rst_n deasserts.
REQ-033 Reset during an in-flight request SHALL abort it with no response; the array word SHALL be unmodified unless the write had already passed ACCESS.

Configuration
REQ-034 With DRAM_REFRESH_EN defined, a counter SHALL raise refresh-pending every REFRESH_PERIOD cycles after reset.
REQ-035 While refresh is pending, the controller SHALL deassert req_ready and wait for IDLE; refresh SHALL take priority over a request presented in the same cycle.
REQ-036 In REFRESH, the controller SHALL close all banks, stay there T_RFC cycles, then return to IDLE.
REQ-037 Without DRAM_REFRESH_EN, the controller SHALL have no refresh counter or REFRESH state, and rows SHALL stay open indefinitely.

Verification
REQ-038 Reset, then write bank0 row3 col1 data 0xDEADBEEF -> rsp_valid 2 edges after accept, rsp_hit=0.
REQ-039 Read bank0 row3 col1 -> rsp_valid 1 edge after accept, rsp_rdata=0xDEADBEEF, rsp_hit=1.
REQ-040 Read bank0 row5 col1 -> rsp_valid 3 edges after accept, rsp_hit=0; then read bank1 row3 -> latency 2, and bank0 stays open at row5.
REQ-041 Assert rst_n=0 during ACTIVATE of a write to bank2 row7 -> no rsp_valid; after reset, all banks are closed and req_ready rises one edge after release.
REQ-042 With DRAM_REFRESH_EN, REFRESH_PERIOD=16 and T_RFC=4: present a request at cycle 16 -> req_ready low for 4+ cycles, and the next access to the previously open row reports rsp_hit=0 with latency 2.

Source files
------------

// File: rtl/dram_bank_ctrl.sv
// Multi-bank DRAM controller model with per-bank open-row tracking and a word array.
// Optional periodic refresh is enabled by defining DRAM_REFRESH_EN.
module dram_bank_ctrl #(
    parameter int unsigned NUM_BANKS      = 4,
    parameter int unsigned ROW_BITS       = 4,
    parameter int unsigned COL_BITS       = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned T_RP           = 1,
    parameter int unsigned T_RCD          = 1,
    parameter int unsigned REFRESH_PERIOD = 64,
    parameter int unsigned T_RFC          = 4,
    localparam int unsigned BANK_BITS     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [BANK_BITS-1:0]  req_bank,
    input  logic [ROW_BITS-1:0]   req_row,
    input  logic [COL_BITS-1:0]   req_col,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_hit
);

    localparam int unsigned ADDR_W = BANK_BITS + ROW_BITS + COL_BITS;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned T_MAX0 = (T_RP > T_RCD) ? T_RP : T_RCD;
    localparam int unsigned T_MAX  = (T_RFC > T_MAX0) ? T_RFC : T_MAX0;
    localparam int unsigned TMR_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    if (T_RP < 1 || T_RCD < 1 || T_RFC < 1 || REFRESH_PERIOD < 2) begin : g_bad_param
        $error("dram_bank_ctrl: timing parameters out of range");
    end

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PRECHARGE = 3'd1;
    localparam logic [2:0] ACTIVATE  = 3'd2;
    localparam logic [2:0] ACCESS    = 3'd3;
`ifdef DRAM_REFRESH_EN
    localparam logic [2:0] REFRESH   = 3'd4;
`endif

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic                  accept_c;
    logic                  hit_c;
    logic                  ready_nxt;
    logic [TMR_W-1:0]      tmr;

    logic                  cap_write;
    logic [BANK_BITS-1:0]  cap_bank;
    logic [ROW_BITS-1:0]   cap_row;
    logic [COL_BITS-1:0]   cap_col;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic                  cap_hit;
    logic [ADDR_W-1:0]     cap_addr;

    logic [NUM_BANKS-1:0]  bank_open;
    logic [ROW_BITS-1:0]   open_row [NUM_BANKS];
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign cap_addr = {cap_bank, cap_row, cap_col};
    assign hit_c    = bank_open[req_bank] && (open_row[req_bank] == req_row);

`ifdef DRAM_REFRESH_EN
    localparam int unsigned REF_W = $clog2(REFRESH_PERIOD);

    logic [REF_W-1:0] ref_cnt;
    logic [REF_W-1:0] ref_cnt_nxt;
    logic             ref_tick;
    logic             ref_pend;
    logic             ref_pend_nxt;
    logic             refresh_c;

    assign ref_tick    = (ref_cnt == REF_W'(REFRESH_PERIOD - 1));
    assign ref_cnt_nxt = ref_tick ? '0 : ref_cnt + REF_W'(1);
    assign refresh_c   = ref_pend | ref_tick;

    // Ready drops one cycle ahead of a tick so refresh always wins over a new request.
    always_comb begin
        ref_pend_nxt = ref_pend | ref_tick;
        if (state == REFRESH && state_nxt == IDLE) begin
            ref_pend_nxt = ref_tick;
        end
        ready_nxt = (state_nxt == IDLE) && !ref_pend_nxt &&
                    (ref_cnt_nxt != REF_W'(REFRESH_PERIOD - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else begin
            ref_cnt  <= ref_cnt_nxt;
            ref_pend <= ref_pend_nxt;
        end
    end
`else
    always_comb begin
        ready_nxt = (state_nxt == IDLE);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        case (state)
            IDLE: begin
`ifdef DRAM_REFRESH_EN
                if (refresh_c) begin
                    state_nxt = REFRESH;
                end else
`endif
                if (req_valid && req_ready) begin
                    accept_c = 1'b1;
                    if (!bank_open[req_bank]) begin
                        state_nxt = ACTIVATE;
                    end else if (hit_c) begin
                        state_nxt = ACCESS;
                    end else begin
                        state_nxt = PRECHARGE;
                    end
                end
            end
            PRECHARGE: if (tmr == '0) state_nxt = ACTIVATE;
            ACTIVATE:  if (tmr == '0) state_nxt = ACCESS;
            ACCESS:    state_nxt = IDLE;
`ifdef DRAM_REFRESH_EN
            REFRESH:   if (tmr == '0) state_nxt = IDLE;
`endif
            default:   state_nxt = IDLE;
        endcase
    end

    // Request capture, bank bookkeeping, phase timer and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_rdata <= '0;
            tmr       <= '0;
            cap_write <= 1'b0;
            cap_bank  <= '0;
            cap_row   <= '0;
            cap_col   <= '0;
            cap_wdata <= '0;
            cap_hit   <= 1'b0;
            bank_open <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                open_row[b] <= '0;
            end
        end else begin
            req_ready <= ready_nxt;
            rsp_valid <= (state == ACCESS);

            if (state_nxt != state) begin
                case (state_nxt)
                    PRECHARGE: tmr <= TMR_W'(T_RP - 1);
                    ACTIVATE:  tmr <= TMR_W'(T_RCD - 1);
`ifdef DRAM_REFRESH_EN
                    REFRESH:   tmr <= TMR_W'(T_RFC - 1);
`endif
                    default:   tmr <= '0;
                endcase
            end else if (tmr != '0) begin
                tmr <= tmr - TMR_W'(1);
            end

            if (accept_c) begin
                cap_write <= req_write;
                cap_bank  <= req_bank;
                cap_row   <= req_row;
                cap_col   <= req_col;
                cap_wdata <= req_wdata;
                cap_hit   <= hit_c;
            end

            if (state == PRECHARGE) begin
                bank_open[cap_bank] <= 1'b0;
            end
            if (state == ACTIVATE && state_nxt == ACCESS) begin
                bank_open[cap_bank] <= 1'b1;
                open_row[cap_bank]  <= cap_row;
            end
`ifdef DRAM_REFRESH_EN
            if (state == REFRESH) begin
                bank_open <= '0;
            end
`endif

            if (state == ACCESS) begin
                rsp_rdata <= cap_write ? cap_wdata : mem[cap_addr];
                rsp_hit   <= cap_hit;
            end
        end
    end

    // Array contents survive reset; reset holds the FSM out of ACCESS, so no stray write.
    always_ff @(posedge clk) begin
        if (state == ACCESS && cap_write) begin
            mem[cap_addr] <= cap_wdata;
        end
    end

endmodule

// File: tb/tb_dram_bank_ctrl.sv
// Directed testbench for dram_bank_ctrl: latency, hit flag, data and reset behaviour.
module tb_dram_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_bank;
    logic [3:0]  req_row;
    logic [1:0]  req_col;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_hit;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat;
    int          wait_cyc;
    logic [31:0] got_rd;
    logic        got_hit;
    logic        rdy_acc;
    logic        rdy_rsp;
    logic        saw;

    dram_bank_ctrl #(
        .NUM_BANKS(4), .ROW_BITS(4), .COL_BITS(2), .DATA_WIDTH(32),
        .T_RP(1), .T_RCD(1), .REFRESH_PERIOD(16), .T_RFC(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_bank(req_bank), .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Present a request, hold it until accepted, then count edges to the response.
    task automatic do_req(input logic wr, input logic [1:0] bank, input logic [3:0] row,
                          input logic [1:0] col, input logic [31:0] wd);
        req_write = wr;
        req_bank  = bank;
        req_row   = row;
        req_col   = col;
        req_wdata = wd;
        req_valid = 1'b1;
        wait_cyc  = 0;
        while (req_ready !== 1'b1 && wait_cyc < 50) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rdy_acc   = req_ready;
        lat       = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (rsp_valid !== 1'b1 && lat < 20);
        got_rd  = rsp_rdata;
        got_hit = rsp_hit;
        rdy_rsp = req_ready;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_bank  = '0;
        req_row   = '0;
        req_col   = '0;
        req_wdata = '0;
        #2;
        check_bit("rst_ready", req_ready, 1'b0);
        check_bit("rst_rsp_valid", rsp_valid, 1'b0);
        check_bit("rst_rsp_hit", rsp_hit, 1'b0);
        check("rst_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_bit("ready_before_first_edge", req_ready, 1'b0);
        @(posedge clk); #1;
        check_bit("ready_first_edge", req_ready, 1'b1);

`ifdef DRAM_REFRESH_EN
        do_req(1'b1, 2'd3, 4'd15, 2'd3, 32'h0F0F_0F0F);
        check("rf_wr_lat", 32'(lat), 32'd2);
        do_req(1'b0, 2'd3, 4'd15, 2'd3, 32'h0);
        check("rf_rd_lat", 32'(lat), 32'd1);
        check_bit("rf_rd_hit", got_hit, 1'b1);
        repeat (9) begin @(posedge clk); #1; end
        check_bit("rf_ready_drop", req_ready, 1'b0);
        do_req(1'b0, 2'd3, 4'd15, 2'd3, 32'h0);
        check_bit("rf_ready_low_4plus", wait_cyc >= 4, 1'b1);
        check("rf_after_lat", 32'(lat), 32'd2);
        check_bit("rf_after_hit", got_hit, 1'b0);
        check("rf_after_data", got_rd, 32'h0F0F_0F0F);
`else
        do_req(1'b1, 2'd0, 4'd3, 2'd1, 32'hDEAD_BEEF);
        check("wr_closed_lat", 32'(lat), 32'd2);
        check_bit("wr_closed_hit", got_hit, 1'b0);
        check("wr_closed_rdata", got_rd, 32'hDEAD_BEEF);
        check_bit("ready_low_after_accept", rdy_acc, 1'b0);
        check_bit("ready_with_rsp", rdy_rsp, 1'b1);

        do_req(1'b0, 2'd0, 4'd3, 2'd1, 32'h0);
        check("rd_hit_lat", 32'(lat), 32'd1);
        check("rd_hit_data", got_rd, 32'hDEAD_BEEF);
        check_bit("rd_hit_hit", got_hit, 1'b1);
        @(posedge clk); #1;
        check_bit("rsp_one_cycle", rsp_valid, 1'b0);
        check("rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

        do_req(1'b0, 2'd0, 4'd5, 2'd1, 32'h0);
        check("conflict_lat", 32'(lat), 32'd3);
        check_bit("conflict_hit", got_hit, 1'b0);

        do_req(1'b0, 2'd1, 4'd3, 2'd0, 32'h0);
        check("other_bank_lat", 32'(lat), 32'd2);
        check_bit("other_bank_hit", got_hit, 1'b0);

        do_req(1'b1, 2'd0, 4'd5, 2'd2, 32'hA5A5_0001);
        check("bank0_still_open_lat", 32'(lat), 32'd1);
        check_bit("bank0_still_open_hit", got_hit, 1'b1);
        check("wr_hit_rdata", got_rd, 32'hA5A5_0001);

        do_req(1'b0, 2'd0, 4'd3, 2'd1, 32'h0);
        check("reopen_lat", 32'(lat), 32'd3);
        check("reopen_data", got_rd, 32'hDEAD_BEEF);

        do_req(1'b1, 2'd2, 4'd7, 2'd0, 32'h1111_2222);
        check("b2_wr_lat", 32'(lat), 32'd2);
        do_req(1'b0, 2'd2, 4'd1, 2'd0, 32'h0);
        check("b2_conflict_lat", 32'(lat), 32'd3);

        // Conflicting write to bank2 row7, reset asserted while it sits in ACTIVATE.
        req_write = 1'b1;
        req_bank  = 2'd2;
        req_row   = 4'd7;
        req_col   = 2'd0;
        req_wdata = 32'hBAD0_BAD0;
        req_valid = 1'b1;
        check_bit("abort_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_bit("abort_rst_ready", req_ready, 1'b0);
        check_bit("abort_rst_valid", rsp_valid, 1'b0);
        saw = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            saw = saw | rsp_valid;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_bit("abort_ready_before_edge", req_ready, 1'b0);
        saw = saw | rsp_valid;
        @(posedge clk); #1;
        check_bit("abort_ready_first_edge", req_ready, 1'b1);
        saw = saw | rsp_valid;
        check_bit("abort_no_rsp", saw, 1'b0);

        do_req(1'b0, 2'd2, 4'd7, 2'd0, 32'h0);
        check("post_rst_b2_lat", 32'(lat), 32'd2);
        check_bit("post_rst_b2_hit", got_hit, 1'b0);
        check("post_rst_b2_data", got_rd, 32'h1111_2222);
        do_req(1'b0, 2'd0, 4'd5, 2'd2, 32'h0);
        check("post_rst_b0_lat", 32'(lat), 32'd2);
        check_bit("post_rst_b0_hit", got_hit, 1'b0);
        check("post_rst_b0_data", got_rd, 32'hA5A5_0001);

        do_req(1'b1, 2'd3, 4'd15, 2'd3, 32'hFFFF_FFFF);
        check("max_addr_wr_lat", 32'(lat), 32'd2);
        do_req(1'b0, 2'd3, 4'd15, 2'd3, 32'h0);
        check("max_addr_rd_lat", 32'(lat), 32'd1);
        check("max_addr_rd_data", got_rd, 32'hFFFF_FFFF);

        repeat (80) @(posedge clk);
        #1;
        do_req(1'b0, 2'd3, 4'd15, 2'd3, 32'h0);
        check("idle_row_open_lat", 32'(lat), 32'd1);
        check_bit("idle_row_open_hit", got_hit, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
